// File: rtl/scroll_bounce_transformer_pkg.sv
// Shared constants and offset-direction encoding for the scroll/bounce coordinate stage.
package scroll_bounce_transformer_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned H_RES_DEF = 640;
    localparam int unsigned V_RES_DEF = 480;

    // Per-axis offset direction; FWD counts up, REV counts down (bounce mode only).
    typedef logic dir_t;
    localparam dir_t FWD = 1'b0;
    localparam dir_t REV = 1'b1;

endpackage

// File: rtl/scroll_bounce_transformer_offset_axis.sv
// One axis of scroll offset: wrap or bounce between 0 and MAX_OFF, stepping once per update.
module scroll_bounce_transformer_offset_axis
    import scroll_bounce_transformer_pkg::*;
#(
    parameter int unsigned STEP    = 2,
    parameter int unsigned MAX_OFF = 127,
    parameter int unsigned RES     = 640
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               update_i,
    input  logic               mode_i,
    output logic [COORD_W-1:0] off_o,
    output dir_t               dir_o
);

    // Reject parameter sets that would let the offset leave the visible range.
    if (MAX_OFF >= RES || STEP < 1 || STEP > MAX_OFF) begin : g_bad_params
        $error("offset_axis: STEP/MAX_OFF out of range");
    end

    localparam logic [COORD_W:0] StepW = (COORD_W + 1)'(STEP);
    localparam logic [COORD_W:0] MaxW  = (COORD_W + 1)'(MAX_OFF);
    localparam logic [COORD_W:0] WrapW = (COORD_W + 1)'(MAX_OFF + 1);

    logic [COORD_W-1:0] off_q, off_d;
    dir_t               dir_q, dir_d;
    logic [COORD_W:0]   sum;
    logic [COORD_W:0]   wrapped;
    logic [COORD_W:0]   diff;

    assign sum     = {1'b0, off_q} + StepW;
    assign wrapped = (sum > MaxW) ? sum - WrapW : sum;
    assign diff    = {1'b0, off_q} - StepW;

    // Next offset/direction; state only moves when an update fires.
    always_comb begin
        off_d = off_q;
        dir_d = dir_q;
        if (update_i) begin
            if (!mode_i) begin
                // Leaving bounce while in REV resumes forward from the current offset.
                off_d = wrapped[COORD_W-1:0];
                dir_d = FWD;
            end else if (dir_q == FWD) begin
                if (sum >= MaxW) begin
                    off_d = MaxW[COORD_W-1:0];
                    dir_d = REV;
                end else begin
                    off_d = sum[COORD_W-1:0];
                end
            end else begin
                if ({1'b0, off_q} <= StepW) begin
                    off_d = '0;
                    dir_d = FWD;
                end else begin
                    off_d = diff[COORD_W-1:0];
                end
            end
        end
    end

    // Offset and direction registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            off_q <= '0;
            dir_q <= FWD;
        end else begin
            off_q <= off_d;
            dir_q <= dir_d;
        end
    end

    assign off_o = off_q;
    assign dir_o = dir_q;

endmodule

// File: rtl/scroll_bounce_transformer.sv
// Scroll/bounce coordinate transform between the VGA sync generator and the pixel decoder.
module scroll_bounce_transformer
    import scroll_bounce_transformer_pkg::*;
#(
    parameter int unsigned H_RES     = H_RES_DEF,
    parameter int unsigned V_RES     = V_RES_DEF,
    parameter int unsigned STEP_X    = 2,
    parameter int unsigned STEP_Y    = 1,
    parameter int unsigned MAX_OFF_X = 127,
    parameter int unsigned MAX_OFF_Y = 63,
    parameter int unsigned FRAME_DIV = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               vsync_i,
    input  logic               enable_i,
    input  logic               mode_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [COORD_W-1:0] new_x_o,
    output logic [COORD_W-1:0] new_y_o,
    output logic               frame_tick_o
);

    localparam int unsigned   CntW  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FRAME_DIV - 1);
    localparam logic [COORD_W:0] HResW = (COORD_W + 1)'(H_RES);
    localparam logic [COORD_W:0] VResW = (COORD_W + 1)'(V_RES);

    logic               vsync_q;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               frame_start;
    logic               update;
    logic [COORD_W-1:0] off_x, off_y;
    dir_t               dir_x, dir_y;
    logic [COORD_W:0]   sum_x, sum_y, fold_x, fold_y;
    logic [COORD_W-1:0] new_x_d, new_y_d, new_x_q, new_y_q;
    logic               tick_q;

    assign frame_start = vsync_i & ~vsync_q;
    assign update      = frame_start & enable_i & (cnt_q == CntLast);

    // Frame divider: counts enabled frame starts, frozen while disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (frame_start && enable_i) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        end
    end

    scroll_bounce_transformer_offset_axis #(
        .STEP    (STEP_X),
        .MAX_OFF (MAX_OFF_X),
        .RES     (H_RES)
    ) u_axis_x (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .update_i (update),
        .mode_i   (mode_i),
        .off_o    (off_x),
        .dir_o    (dir_x)
    );

    scroll_bounce_transformer_offset_axis #(
        .STEP    (STEP_Y),
        .MAX_OFF (MAX_OFF_Y),
        .RES     (V_RES)
    ) u_axis_y (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .update_i (update),
        .mode_i   (mode_i),
        .off_o    (off_y),
        .dir_o    (dir_y)
    );

    // Shift visible coordinates by the offset, folding back into the visible range;
    // blanking coordinates pass through untouched.
    always_comb begin
        sum_x   = {1'b0, x_i} + {1'b0, off_x};
        sum_y   = {1'b0, y_i} + {1'b0, off_y};
        fold_x  = (sum_x >= HResW) ? sum_x - HResW : sum_x;
        fold_y  = (sum_y >= VResW) ? sum_y - VResW : sum_y;
        new_x_d = ({1'b0, x_i} < HResW) ? fold_x[COORD_W-1:0] : x_i;
        new_y_d = ({1'b0, y_i} < VResW) ? fold_y[COORD_W-1:0] : y_i;
    end

    // Edge detector, divider and output registers; vsync_q resets high so a vsync
    // already asserted at reset release is not seen as a frame start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vsync_q <= 1'b1;
            cnt_q   <= '0;
            new_x_q <= '0;
            new_y_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            cnt_q   <= cnt_d;
            new_x_q <= new_x_d;
            new_y_q <= new_y_d;
            tick_q  <= update;
        end
    end

    assign new_x_o      = new_x_q;
    assign new_y_o      = new_y_q;
    assign frame_tick_o = tick_q;

    // Direction is internal state only; not needed at the top level.
    logic unused_dir;
    assign unused_dir = dir_x ^ dir_y;

endmodule

// File: tb/tb_scroll_bounce_transformer.sv
// Self-checking bench: directed phases plus randomized frames against a frame-level model.
module tb_scroll_bounce_transformer;

    localparam int H_RES = 640, V_RES = 480;
    localparam int STEP_X = 2, STEP_Y = 1, MAX_X = 127, MAX_Y = 63, FDIV = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync, enable, mode;
    logic [9:0] x, y;
    logic [9:0] new_x, new_y;
    logic       frame_tick;

    int checks = 0;
    int passes = 0;
    int ticks_seen;

    // Reference model state
    int m_off_x, m_off_y, m_cnt;
    bit m_rev_x, m_rev_y;

    always #5 clk = ~clk;

    scroll_bounce_transformer #(
        .H_RES     (H_RES),
        .V_RES     (V_RES),
        .STEP_X    (STEP_X),
        .STEP_Y    (STEP_Y),
        .MAX_OFF_X (MAX_X),
        .MAX_OFF_Y (MAX_Y),
        .FRAME_DIV (FDIV)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .vsync_i      (vsync),
        .enable_i     (enable),
        .mode_i       (mode),
        .x_i          (x),
        .y_i          (y),
        .new_x_o      (new_x),
        .new_y_o      (new_y),
        .frame_tick_o (frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_off_x = 0; m_off_y = 0; m_cnt = 0; m_rev_x = 0; m_rev_y = 0;
    endtask

    task automatic axis_step(inout int off, inout bit rev, input int step, input int mx,
                             input bit bounce);
        if (!bounce) begin
            off = (off + step) % (mx + 1);
            rev = 0;
        end else if (!rev) begin
            off = off + step;
            if (off >= mx) begin off = mx; rev = 1; end
        end else begin
            off = off - step;
            if (off <= 0) begin off = 0; rev = 0; end
        end
    endtask

    function automatic int tx(input int c, input int off, input int res);
        return (c < res) ? (c + off) % res : c;
    endfunction

    // One vsync pulse (rising edge then low); model advances on the frame start.
    task automatic pulse(input string tag);
        bit exp_tick;
        vsync = 1'b1;
        tick();
        exp_tick = 0;
        if (enable) begin
            if (m_cnt == FDIV - 1) begin
                m_cnt = 0;
                exp_tick = 1;
                axis_step(m_off_x, m_rev_x, STEP_X, MAX_X, mode);
                axis_step(m_off_y, m_rev_y, STEP_Y, MAX_Y, mode);
            end else begin
                m_cnt++;
            end
        end
        chk({tag, "_tick"}, 32'(frame_tick), 32'(exp_tick));
        if (frame_tick === 1'b1) ticks_seen++;
        vsync = 1'b0;
        tick();
        chk({tag, "_tick_low"}, 32'(frame_tick), 32'd0);
    endtask

    task automatic xy(input string tag, input int xv, input int yv);
        x = 10'(xv);
        y = 10'(yv);
        tick();
        chk({tag, "_x"}, 32'(new_x), 32'(tx(xv, m_off_x, H_RES)));
        chk({tag, "_y"}, 32'(new_y), 32'(tx(yv, m_off_y, V_RES)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; vsync = 1'b0; enable = 1'b1; mode = 1'b0; x = '0; y = '0;
        ticks_seen = 0;
        model_reset();

        // Reset state, then identity transform with zero offsets
        #2;
        chk("rst_new_x", 32'(new_x), 32'd0);
        chk("rst_new_y", 32'(new_y), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        tick();
        rst_n = 1'b1;
        x = 10'd100; y = 10'd50;
        tick();
        chk("id_x", 32'(new_x), 32'd100);
        chk("id_y", 32'(new_y), 32'd50);
        chk("id_tick", 32'(frame_tick), 32'd0);

        // Wrap: 128 frame starts -> 64 updates, both offsets back at 0
        mode = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < 128; i++) begin
            pulse("wrap");
            if (i % 16 == 15) xy("wrap_off", 0, 0);
        end
        chk("wrap_tick_count", 32'(ticks_seen), 32'd64);
        xy("wrap_zero", 0, 0);
        chk("wrap_off_x0", 32'(new_x), 32'd0);
        xy("wrap_639", 639, 0);
        chk("wrap_639_const", 32'(new_x), 32'd639);

        // Bounce sequence on x: 0,2..126,127,125..1,0,2
        do_reset();
        mode = 1'b1;
        for (int u = 1; u <= 129; u++) begin
            pulse("bnc");
            pulse("bnc");
            xy("bnc_off", 0, 0);
            if (u == 63) chk("bnc_126", 32'(new_x), 32'd126);
            if (u == 64) chk("bnc_127", 32'(new_x), 32'd127);
            if (u == 65) chk("bnc_125", 32'(new_x), 32'd125);
            if (u == 127) chk("bnc_1", 32'(new_x), 32'd1);
            if (u == 128) chk("bnc_0", 32'(new_x), 32'd0);
            if (u == 129) chk("bnc_2", 32'(new_x), 32'd2);
        end

        // Boundaries: off_x = 127 with x = 600 / 700
        do_reset();
        mode = 1'b1;
        for (int u = 0; u < 64; u++) begin pulse("to127"); pulse("to127"); end
        xy("b600", 600, 479);
        chk("b600_const", 32'(new_x), 32'd87);
        xy("b700", 700, 500);
        chk("b700_const", 32'(new_x), 32'd700);
        // off_y = 1 with y = 479 -> 0
        do_reset();
        mode = 1'b0;
        pulse("y1"); pulse("y1");
        xy("y479", 0, 479);
        chk("y479_const", 32'(new_y), 32'd0);

        // Randomized frames: random enable/mode, random coordinates
        for (int i = 0; i < 300; i++) begin
            enable = 1'($urandom_range(0, 3) != 0);
            mode = 1'($urandom_range(0, 1));
            pulse("rnd");
            if ($urandom_range(0, 1) == 1) xy("rnd_xy", $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
        enable = 1'b1;

        // enable = 0 across 5 edges: no ticks, offsets frozen
        begin
            int sx, sy;
            sx = m_off_x; sy = m_off_y;
            enable = 1'b0;
            ticks_seen = 0;
            for (int i = 0; i < 5; i++) pulse("dis");
            chk("dis_ticks", 32'(ticks_seen), 32'd0);
            xy("dis_off", 0, 0);
            chk("dis_x_held", 32'(new_x), 32'(sx));
            chk("dis_y_held", 32'(new_y), 32'(sy));
            enable = 1'b1;
            pulse("dis_resume");
            pulse("dis_resume");
            xy("dis_resume_off", 0, 0);
        end

        // vsync high at reset release: no frame start
        rst_n = 1'b0; vsync = 1'b1;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("vs_hi_tick", 32'(frame_tick), 32'd0);
        end
        vsync = 1'b0;
        mode = 1'b0;
        xy("vs_hi_off", 0, 0);
        pulse("vs_hi_after");
        pulse("vs_hi_after");
        xy("vs_hi_upd", 0, 0);

        // Mid-frame asynchronous reset with off_x = 40
        do_reset();
        mode = 1'b0;
        for (int u = 0; u < 20; u++) begin pulse("to40"); pulse("to40"); end
        xy("pre40", 0, 0);
        chk("pre40_const", 32'(new_x), 32'd40);
        x = 10'd200;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_x", 32'(new_x), 32'd0);
        chk("async_y", 32'(new_y), 32'd0);
        chk("async_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        model_reset();
        x = 10'd10;
        tick();
        chk("post_rst_10", 32'(new_x), 32'd10);
        xy("post_rst_off", 0, 0);
        chk("post_rst_off0", 32'(new_x), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/scroll_bounce_transformer.md
Name: scroll_bounce_transformer

Overview:
- Coordinate-transform stage between the VGA sync generator and the pixel decoder.
- Takes the raw pixel_x/pixel_y and the active-high vsync, and keeps per-axis scroll offsets that are updated once per N frames.
- Offsets either wrap around or bounce between 0 and a limit.
- Outputs registered transformed coordinates, which the pixel decoder consumes directly.

Parameters:
- H_RES, 640, visible width; transformed x wraps modulo this value.
- V_RES, 480, visible height; transformed y wraps modulo this value.
- STEP_X, 2, x offset change per update (1..MAX_OFF_X).
- STEP_Y, 1, y offset change per update (1..MAX_OFF_Y).
- MAX_OFF_X, 127, x offset upper limit (< H_RES).
- MAX_OFF_Y, 63, y offset upper limit (< V_RES).
- FRAME_DIV, 2, number of frame starts per offset update (>= 1).

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- vsync, input, 1, active-high vertical sync.
- enable, input, 1, 1 = animate; 0 = freeze offsets and frame counter.
- mode, input, 1, 0 = wrap, 1 = bounce; sampled at each update.
- x, input, 10, raw pixel_x.
- y, input, 10, raw pixel_y.
- new_x, output, 10, transformed x.
- new_y, output, 10, transformed y.
- frame_tick, output, 1, one-cycle pulse in the cycle after an offset update.

Behaviour:
- Clocking and reset: single clock domain, asynchronous active-low reset.
- Reset values:
  - off_x = 0, off_y = 0, dir_x = dir_y = FWD.
  - frame_cnt = 0, new_x = new_y = 0, frame_tick = 0.
  - vsync_d = 1, so that a vsync already high at reset release produces no frame start.
- Frame start: fs = vsync & ~vsync_d; vsync_d <= vsync every cycle.
- Frame divider: on fs with enable = 1:
  - if frame_cnt == FRAME_DIV-1, then frame_cnt <= 0 and an update fires;
  - otherwise frame_cnt increments.
  - With enable = 0, frame_cnt and the offsets hold.
- Update, wrap mode (mode = 0), per axis:
  - off <= (off + STEP) mod (MAX_OFF + 1), computed as: if off + STEP > MAX_OFF then off + STEP - (MAX_OFF + 1).
  - dir <= FWD.
- Update, bounce mode (mode = 1), per-axis 2-state FSM {FWD, REV}:
  - FWD: if off + STEP >= MAX_OFF, then off <= MAX_OFF and dir <= REV; else off <= off + STEP.
  - REV: if off <= STEP, then off <= 0 and dir <= FWD; else off <= off - STEP.
  - Offsets never leave [0, MAX_OFF].
- Mode switching: a switch takes effect at the next update only. Switching bounce to wrap while in REV moves forward from the current offset.
- Offset stability: offsets change only on an update, so they are constant for the whole visible frame (updates occur at a vsync edge, inside vertical blanking).
- frame_tick: asserted for exactly 1 clk in the cycle after the update edge.
- Transform (registered, latency 1 clk from x/y to new_x/new_y):
  - If x < H_RES: s = x + off_x (11-bit); new_x <= (s >= H_RES) ? s - H_RES : s.
  - If x >= H_RES (blanking): new_x <= x unchanged.
  - y is handled identically with V_RES and off_y.
- Arithmetic widths: all sums are 11 bits wide internally, with no overflow given the parameter limits.
- Reset mid-frame: all state clears immediately and asynchronously; the output is identity from the first clk after release.

Decomposition:
- Shared package vga_pkg holds:
  - H_RES/V_RES defaults;
  - the dir_t enum {FWD, REV};
  - the 10-bit coordinate width constant.
- One natural sub-module, offset_axis: the per-axis offset register plus the FSM.
  - Parameters: STEP, MAX_OFF, RES.
  - Inputs: update, mode. Outputs: off, dir.
  - Instantiated twice. The top holds edge detection, the frame divider and the output registers.

Test Plan:
- Reset, then x = 100, y = 50 with no vsync edge -> next clk new_x = 100, new_y = 50, frame_tick = 0.
- Wrap, FRAME_DIV = 2, STEP_X = 2, MAX_OFF_X = 127, 128 vsync rising edges -> 64 frame_ticks, off_x wraps back to 0. Then x = 639 -> new_x = 639.
- Bounce, STEP_X = 2, MAX_OFF_X = 127, drive updates -> off_x sequence 0, 2, ..., 126, 127 (dir REV), 125, ..., 1, 0 (dir FWD), 2.
- Offset 127 with x = 600 -> new_x = 87; x = 700 (blanking) -> new_x = 700; y = 479 with off_y = 1 -> new_y = 0.
- enable = 0 across 5 vsync edges -> offsets and frame_cnt unchanged, no frame_tick. vsync high at reset release -> no update.
- Assert reset_n low mid-frame with off_x = 40 -> new_x and off_x become 0 asynchronously; after release, x = 10 -> new_x = 10 one clk later.
